// File: rtl/alu_decoder_if.sv
// Bundles the instruction/operand inputs and all decode/ALU outputs of alu_decoder.
// Latency: n/a (wires only); the decoder registers everything one cycle.
// Backpressure: none; the block accepts a new instruction and operands every cycle.
interface alu_decoder_if;
    logic [31:0] InstrReg;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] const_imm;     // "const" is a reserved word, hence the suffix
    logic [25:0] address;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        RegDst;
    logic        ALUSrc;
    logic        PCSrc;
    logic        Branch;
    logic [1:0]  ALUOp;
    logic [31:0] out;
    logic        zero;

    // Driver side: supplies instruction and operands, observes results.
    modport master (
        output InstrReg, a, b,
        input  opcode, rs, rt, rd, shamt, funct, const_imm, address,
        input  RegWrite, MemRead, MemWrite, RegDst, ALUSrc, PCSrc, Branch,
        input  ALUOp, out, zero
    );

    // Decoder side.
    modport slave (
        input  InstrReg, a, b,
        output opcode, rs, rt, rd, shamt, funct, const_imm, address,
        output RegWrite, MemRead, MemWrite, RegDst, ALUSrc, PCSrc, Branch,
        output ALUOp, out, zero
    );
endinterface

// File: rtl/alu_decoder.sv
// Instruction field/control decoder feeding a small registered ALU; shifts built only with ALU_DECODER_SHIFT_EN.
// Latency: decode 1 cycle; ALU 1 further cycle (instr at edge N is applied to a/b sampled at edge N+1).
// Backpressure: none; new instruction and operands accepted every cycle.
module alu_decoder (
    input  logic           clk,
    input  logic           reset,     // asynchronous, active-low
    alu_decoder_if.slave   bus
);

    logic [5:0]  opcode_q,  opcode_d;
    logic [4:0]  rs_q,      rs_d;
    logic [4:0]  rt_q,      rt_d;
    logic [4:0]  rd_q,      rd_d;
    logic [4:0]  shamt_q,   shamt_d;
    logic [5:0]  funct_q,   funct_d;
    logic [15:0] const_q,   const_d;
    logic [25:0] address_q, address_d;
    logic [6:0]  ctrl_q,    ctrl_d;    // {RegWrite, MemRead, MemWrite, RegDst, ALUSrc, PCSrc, Branch}
    logic [1:0]  aluop_q,   aluop_d;
    logic [31:0] out_q,     out_d;
    logic        zero_q,    zero_d;

    // Upper instruction half is architecturally ignored.
    logic unused_instr_hi;
    assign unused_instr_hi = ^bus.InstrReg[31:16];

    // Field extraction and control decode of the low instruction half.
    always_comb begin
        opcode_d  = {2'b00, bus.InstrReg[15:12]};
        rs_d      = {2'b00, bus.InstrReg[11:9]};
        rt_d      = {2'b00, bus.InstrReg[8:6]};
        rd_d      = {2'b00, bus.InstrReg[5:3]};
        shamt_d   = {2'b00, bus.InstrReg[8:6]};
        funct_d   = {3'b000, bus.InstrReg[2:0]};
        const_d   = {{10{bus.InstrReg[5]}}, bus.InstrReg[5:0]};
        address_d = {14'd0, bus.InstrReg[11:0]};
        ctrl_d    = 7'b0;
        aluop_d   = 2'b00;
        case (bus.InstrReg[15:12])
            4'b0000: begin ctrl_d = 7'b1001000; aluop_d = 2'b10; end  // R-type
            4'b0100: begin ctrl_d = 7'b1000100; aluop_d = 2'b00; end  // addi
            4'b1000: begin ctrl_d = 7'b1100100; aluop_d = 2'b00; end  // lw
            4'b1100: begin ctrl_d = 7'b0010100; aluop_d = 2'b00; end  // sw
            4'b1110,
            4'b1111: begin ctrl_d = 7'b0000001; aluop_d = 2'b01; end  // beq / bne
            4'b0010: begin ctrl_d = 7'b0000010; aluop_d = 2'b00; end  // j
            default: begin ctrl_d = 7'b0;       aluop_d = 2'b00; end
        endcase
    end

    // ALU result from the operands on the bus and the previously registered decode.
    always_comb begin
        out_d = 32'd0;
        case (aluop_q)
            2'b00: out_d = bus.a + bus.b;
            2'b01: out_d = bus.a - bus.b;
            2'b10: begin
                case (funct_q[2:0])
                    3'b000: out_d = bus.a + bus.b;
                    3'b001: out_d = bus.a - bus.b;
                    3'b010: out_d = bus.a & bus.b;
                    3'b011: out_d = bus.a | bus.b;
                    3'b100: out_d = bus.a ^ bus.b;
`ifdef ALU_DECODER_SHIFT_EN
                    3'b101: out_d = bus.a << shamt_q[2:0];
                    3'b110: out_d = bus.a >> shamt_q[2:0];
`else
                    3'b101: out_d = 32'd0;
                    3'b110: out_d = 32'd0;
`endif
                    3'b111: out_d = ($signed(bus.a) < $signed(bus.b)) ? 32'd1 : 32'd0;
                    default: out_d = 32'd0;
                endcase
            end
            default: out_d = 32'd0;
        endcase
        // Derived from the same value that gets registered so out/zero never disagree.
        zero_d = (out_d == 32'd0);
    end

    // Pipeline registers; reset clears every output regardless of clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opcode_q  <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            shamt_q   <= '0;
            funct_q   <= '0;
            const_q   <= '0;
            address_q <= '0;
            ctrl_q    <= '0;
            aluop_q   <= '0;
            out_q     <= '0;
            zero_q    <= 1'b0;
        end else begin
            opcode_q  <= opcode_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            shamt_q   <= shamt_d;
            funct_q   <= funct_d;
            const_q   <= const_d;
            address_q <= address_d;
            ctrl_q    <= ctrl_d;
            aluop_q   <= aluop_d;
            out_q     <= out_d;
            zero_q    <= zero_d;
        end
    end

    assign bus.opcode    = opcode_q;
    assign bus.rs        = rs_q;
    assign bus.rt        = rt_q;
    assign bus.rd        = rd_q;
    assign bus.shamt     = shamt_q;
    assign bus.funct     = funct_q;
    assign bus.const_imm = const_q;
    assign bus.address   = address_q;
    assign bus.RegWrite  = ctrl_q[6];
    assign bus.MemRead   = ctrl_q[5];
    assign bus.MemWrite  = ctrl_q[4];
    assign bus.RegDst    = ctrl_q[3];
    assign bus.ALUSrc    = ctrl_q[2];
    assign bus.PCSrc     = ctrl_q[1];
    assign bus.Branch    = ctrl_q[0];
    assign bus.ALUOp     = aluop_q;
    assign bus.out       = out_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_decoder.sv
// Directed bench for alu_decoder: decode fields/controls, ALU ops, reset behaviour.
// Latency: inputs driven 1 time unit after a rising edge, outputs checked 1 unit after the next.
// Backpressure: none.
module tb_alu_decoder;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    alu_decoder_if bus ();

    alu_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {RegWrite, MemRead, MemWrite, RegDst, ALUSrc, PCSrc, Branch, ALUOp}
    function automatic logic [8:0] ctrl_vec();
        return {bus.RegWrite, bus.MemRead, bus.MemWrite, bus.RegDst,
                bus.ALUSrc, bus.PCSrc, bus.Branch, bus.ALUOp};
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_fld"}, {32'd0, bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct}, 64'd0);
        chk({tag, "_imm"}, {22'd0, bus.const_imm, bus.address}, 64'd0);
        chk({tag, "_ctl"}, {54'd0, ctrl_vec(), bus.zero}, 64'd0);
        chk({tag, "_out"}, {32'd0, bus.out}, 64'd0);
    endtask

    // ALU-op instruction, operands, expected out and zero
    task automatic alu_vec(input string tag, input logic [15:0] ins,
                           input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] exp_out, input logic exp_zero);
        bus.InstrReg = {16'hA5A5, ins};
        tick();
        bus.a = av;
        bus.b = bv;
        tick();
        chk({tag, "_out"},  {32'd0, bus.out}, {32'd0, exp_out});
        chk({tag, "_zero"}, {63'd0, bus.zero}, {63'd0, exp_zero});
    endtask

    localparam int NCTL = 8;
    localparam logic [15:0] CTL_INS [NCTL] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000,
                                               16'hE000, 16'hF000, 16'h2ABC, 16'h3000};
    localparam logic [8:0]  CTL_EXP [NCTL] = '{9'b100100010, 9'b100010000, 9'b110010000, 9'b001010000,
                                               9'b000000101, 9'b000000101, 9'b000001000, 9'b000000000};

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.InstrReg = 32'hFFFF_0D10;
        bus.a = 32'd10;
        bus.b = 32'd20;
        #2;
        check_all_zero("rst_init");
        tick();
        check_all_zero("rst_hold");

        // First edge after reset: decode + ALU add (ALUOp reset value is 00)
        reset = 1'b1;
        tick();
        chk("post_rst_add", {32'd0, bus.out}, 64'd30);
        chk("rtype_fld", {32'd0, bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct},
            {32'd0, 6'd0, 5'd6, 5'd4, 5'd2, 5'd4, 6'd0});
        chk("rtype_imm", {22'd0, bus.const_imm, bus.address}, {22'd0, 16'h0010, 26'hD10});
        chk("rtype_ctl", {55'd0, ctrl_vec()}, {55'd0, 9'b100100010});

        // Control table for every listed opcode plus an unlisted one
        for (int i = 0; i < NCTL; i++) begin
            bus.InstrReg = {16'h5A5A, CTL_INS[i]};
            tick();
            chk($sformatf("ctl_%h", CTL_INS[i]), {55'd0, ctrl_vec()}, {55'd0, CTL_EXP[i]});
        end
        chk("j_addr", {38'd0, bus.address}, {38'd0, 26'h0000000});   // last entry 3000 -> addr 0
        chk("unk_opc", {58'd0, bus.opcode}, {58'd0, 6'h03});

        // addi with negative immediate
        bus.InstrReg = 32'h0000_4D3F;
        tick();
        chk("addi_const", {48'd0, bus.const_imm}, {48'd0, 16'hFFFF});
        chk("addi_ctl", {55'd0, ctrl_vec()}, {55'd0, 9'b100010000});
        alu_vec("addi", 16'h4D3F, 32'd5, 32'hFFFF_FFFF, 32'd4, 1'b0);

        // beq subtraction, including wrap-around
        alu_vec("beq_eq",  16'hE141, 32'd7, 32'd7, 32'd0, 1'b1);
        alu_vec("beq_ne",  16'hE141, 32'd7, 32'd3, 32'd4, 1'b0);
        alu_vec("sub_wrap", 16'hE141, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
        alu_vec("add_wrap", 16'h8000, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0);

        // R-type funct ops
        alu_vec("r_add", 16'h0000, 32'd3, 32'd4, 32'd7, 1'b0);
        alu_vec("r_sub", 16'h0001, 32'd3, 32'd4, 32'hFFFF_FFFF, 1'b0);
        alu_vec("r_and", 16'h0002, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0);
        alu_vec("r_or",  16'h0003, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0);
        alu_vec("r_xor", 16'h0004, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0);
        alu_vec("r_slt_t", 16'h0007, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        alu_vec("r_slt_f", 16'h0007, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);
`ifdef ALU_DECODER_SHIFT_EN
        alu_vec("r_sll3", 16'h00C5, 32'd1, 32'd0, 32'd8, 1'b0);
        alu_vec("r_sll7", 16'h01C5, 32'd1, 32'd0, 32'h80, 1'b0);
        alu_vec("r_srl3", 16'h00C6, 32'h8000_0000, 32'd0, 32'h1000_0000, 1'b0);
`else
        alu_vec("r_sll3", 16'h00C5, 32'd1, 32'd0, 32'd0, 1'b1);
        alu_vec("r_sll7", 16'h01C5, 32'd1, 32'd0, 32'd0, 1'b1);
        alu_vec("r_srl3", 16'h00C6, 32'h8000_0000, 32'd0, 32'd0, 1'b1);
`endif

        // Unlisted opcode: no controls, ALU adds
        alu_vec("unk", 16'h3000, 32'd2, 32'd3, 32'd5, 1'b0);
        chk("unk_ctl", {55'd0, ctrl_vec()}, 64'd0);

        // Mid-run asynchronous reset, cleared before any clock edge
        bus.InstrReg = 32'h0000_0D10;
        bus.a = 32'd1;
        bus.b = 32'd1;
        tick();
        reset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        tick();
        check_all_zero("rst_mid_clk");
        reset = 1'b1;
        bus.a = 32'd100;
        bus.b = 32'd23;
        tick();
        chk("rst_mid_add", {32'd0, bus.out}, 64'd123);
        chk("rst_mid_ctl", {55'd0, ctrl_vec()}, {55'd0, 9'b100100010});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
